// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the FIFO write arbiter and its producers/FIFO.
// The master modport is the arbiter's view; slave is the producer/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic                          full;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            ack;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic                          busy;

  modport master (
    input  req, req_data, req_last, full,
    output gnt, ack, wr_en, wr_data, busy
  );

  modport slave (
    output req, req_data, req_last, full,
    input  gnt, ack, wr_en, wr_data, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ producers.
// One producer owns the port per burst of up to MAX_BURST words; writes stall while full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic               wr_clk,
  input  logic               wr_rstn,
  fifo_wr_arbiter_if.master  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              r_state, w_state_nxt;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0]    r_gidx, w_gidx_nxt;
  logic [IDX_W-1:0]    r_rr_last, w_rr_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;

  logic                  w_found;
  logic [IDX_W-1:0]      w_pick;
  logic                  w_req_g;
  logic                  w_last_g;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_accept;

  // Search starts one past the last owner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_found && bus.req[IDX_W'((int'(r_rr_last) + k) % NUM_REQ)]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'((int'(r_rr_last) + k) % NUM_REQ);
      end
    end
  end

  assign w_req_g  = |(r_gnt & bus.req);
  assign w_last_g = |(r_gnt & bus.req_last);

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gidx == IDX_W'(i)) begin
        w_sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_gidx_nxt  = r_gidx;
    w_cnt_nxt   = r_cnt;
    w_rr_nxt    = r_rr_last;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        w_gnt_nxt = '0;
        if (w_found) begin
          w_gnt_nxt   = NUM_REQ'(1) << w_pick;
          w_gidx_nxt  = w_pick;
          w_cnt_nxt   = '0;
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        if (!w_req_g) begin
          // Owner withdrew: give up the port without writing.
          w_gnt_nxt   = '0;
          w_rr_nxt    = r_gidx;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (!bus.full) begin
          w_accept  = 1'b1;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (w_last_g || (r_cnt + CNT_W'(1) == CNT_W'(MAX_BURST))) begin
            w_gnt_nxt   = '0;
            w_rr_nxt    = r_gidx;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_gidx    <= '0;
      r_cnt     <= '0;
      r_rr_last <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gidx    <= w_gidx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rr_last <= w_rr_nxt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.ack     = r_gnt & {NUM_REQ{w_accept}};
  assign bus.wr_en   = w_accept;
  assign bus.wr_data = w_accept ? w_sel_data : '0;
  assign bus.busy    = (r_state == BURST);

endmodule
